// File: rtl/seq_mult4.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult4 (with bit4_adder)
// Description : 4x4 unsigned shift-and-add multiplier, one add/shift per clock.
//               Optional macro SEQ_MULT4_ZERO_BYPASS_EN: zero operands finish
//               immediately without entering RUN.
// Revision    : 1.0 - initial release
// ============================================================================

module bit4_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_ripple
            assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[4];
endmodule

module seq_mult4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_m;
    logic [3:0]  r_q;
    logic [3:0]  r_a;
    logic [1:0]  r_cnt;
    logic [7:0]  r_product;
    logic [3:0]  w_addend;
    logic [3:0]  w_sum;
    logic        w_carry;
    logic        w_accept;
    logic        w_zero;
    logic [7:0]  w_shifted;

`ifdef SEQ_MULT4_ZERO_BYPASS_EN
    assign w_zero = (a == 4'h0) || (b == 4'h0);
`else
    assign w_zero = 1'b0;
`endif

    // A new operation may only be accepted outside RUN.
    assign w_accept  = start && (r_state != S_RUN);
    assign w_addend  = r_q[0] ? r_m : 4'h0;
    assign w_shifted = {w_carry, w_sum, r_q[3:1]};

    bit4_adder u_adder (
        .a    (r_a),
        .b    (w_addend),
        .sum  (w_sum),
        .cout (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= 4'h0;
            r_q       <= 4'h0;
            r_a       <= 4'h0;
            r_cnt     <= 2'd0;
            r_product <= 8'h00;
        end else if (w_accept) begin
            r_m   <= a;
            r_q   <= b;
            r_a   <= 4'h0;
            r_cnt <= 2'd0;
            if (w_zero) begin
                r_product <= 8'h00;
            end
        end else if (r_state == S_RUN) begin
            {r_a, r_q} <= w_shifted;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_product <= w_shifted;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
endmodule

`default_nettype wire

// File: tb/tb_seq_mult4.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult4
// Description : Directed self-checking bench for seq_mult4.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_seq_mult4;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    seq_mult4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge so they are sampled at the next edge (T0).
    task automatic launch(input logic [3:0] ta, input logic [3:0] tb);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after T0; returns at the negedge where done is seen.
    task automatic wait_done(output int lat, output int bcnt, output int ovl);
        lat  = 0;
        bcnt = 0;
        ovl  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (busy && done) ovl++;
    endtask

    initial begin
        int lat, bcnt, ovl, dcnt;
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_product", product, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        dcnt = 0;
        bcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("idle_done", dcnt, 0);
        check("idle_busy", bcnt, 0);
        check("idle_product", product, 0);

        // 15*15: old product must hold during the run
        launch(4'd15, 4'd15);
        @(negedge clk);
        @(negedge clk);
        check("hold_during_run", product, 0);
        lat = 2; bcnt = 2; ovl = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check("max_latency", lat, 4);
        check("max_busy_cycles", bcnt, 4);
        check("max_product", product, 225);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // start during RUN is ignored
        launch(4'd3, 4'd5);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        @(negedge clk);
        start = 1'b0;
        lat = 2; bcnt = 0; ovl = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ignore_latency", lat, 4);
        check("busy_ignore_product", product, 15);
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("busy_ignore_single_done", dcnt, 0);

        // back-to-back 6*7 then 9*11 launched in the DONE cycle
        launch(4'd6, 4'd7);
        wait_done(lat, bcnt, ovl);
        check("b2b_first_product", product, 42);
        check("b2b_first_overlap", ovl, 0);
        launch(4'd9, 4'd11);
        check("b2b_no_idle_busy", busy, 1);
        wait_done(lat, bcnt, ovl);
        check("b2b_second_latency", lat, 4);
        check("b2b_second_product", product, 99);

        // reset mid-run
        launch(4'd13, 4'd11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_product", product, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        launch(4'd2, 4'd3);
        wait_done(lat, bcnt, ovl);
        check("after_rst_product", product, 6);

        // zero operand
        launch(4'd0, 4'd9);
        wait_done(lat, bcnt, ovl);
`ifdef SEQ_MULT4_ZERO_BYPASS_EN
        check("zero_latency", lat, 0);
`else
        check("zero_latency", lat, 4);
        check("zero_busy_cycles", bcnt, 4);
`endif
        check("zero_product", product, 0);
        check("zero_overlap", ovl, 0);
        @(negedge clk);
        check("zero_back_idle", done, 0);

        // exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                launch(i[3:0], j[3:0]);
                wait_done(lat, bcnt, ovl);
                check($sformatf("sweep_%0dx%0d", i, j), product, i * j);
                if (ovl != 0) check("sweep_overlap", ovl, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
